// File: rtl/pwm_demodulator_pkg.sv
// Shared definitions for the PWM receive path: FSM state encoding and the default counter width.
package pwm_demodulator_pkg;

  localparam int DEFAULT_CNT_W = 12;

  typedef enum logic [1:0] {
    ST_WAIT_RISE = 2'd0,
    ST_HIGH      = 2'd1,
    ST_LOW       = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronises an asynchronous pin and reports its settled level plus registered rise/fall pulses.
// Edges are masked until the pipeline has refilled after reset, so reset zeros never read as an edge.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic async_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_q;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  // The delayed level lines up in time with the registered rise/fall pulses.
  assign s        = d_q;

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      sync_q <= '0;
      d_q    <= 1'b0;
      warm_q <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      d_q    <= sync_lvl;
      warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      rise   <= warm_q[SYNC_STAGES] & sync_lvl & ~d_q;
      fall   <= warm_q[SYNC_STAGES] & ~sync_lvl & d_q;
    end
  end

endmodule

// File: rtl/pwm_demodulator.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input, publishing one
// width/period pair per completed period and flagging inputs stuck at either level.
module pwm_demodulator
  import pwm_demodulator_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s;
  logic             rise;
  logic             fall;

  pwm_state_t       state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_inc, per_inc;
  logic             per_sat;
  logic [CNT_W-1:0] width_d, period_d;
  logic             valid_d, stuck_high_d, stuck_low_d;
  logic             timeout, timeout_high;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .CLOCK_50(CLOCK_50),
    .RST_N   (RST_N),
    .async_in(pwm_in),
    .s       (s),
    .rise    (rise),
    .fall    (fall)
  );

  assign per_sat = (per_q == CNT_MAX);
  assign per_inc = per_sat ? CNT_MAX : per_q + CNT_ONE;
  assign hi_inc  = (hi_q == CNT_MAX) ? CNT_MAX : hi_q + CNT_ONE;

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q     <= ST_WAIT_RISE;
      hi_q        <= '0;
      per_q       <= '0;
      meas_width  <= '0;
      meas_period <= '0;
      meas_valid  <= 1'b0;
      stuck_high  <= 1'b0;
      stuck_low   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      per_q       <= per_d;
      meas_width  <= width_d;
      meas_period <= period_d;
      meas_valid  <= valid_d;
      stuck_high  <= stuck_high_d;
      stuck_low   <= stuck_low_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    per_d        = per_q;
    width_d      = meas_width;
    period_d     = meas_period;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high;
    stuck_low_d  = stuck_low;
    timeout      = 1'b0;
    timeout_high = 1'b0;

    case (state_q)
      ST_WAIT_RISE: begin
        if (rise) begin
          hi_d    = CNT_ONE;
          per_d   = CNT_ONE;
          state_d = ST_HIGH;
        end else if (per_sat) begin
          timeout      = 1'b1;
          timeout_high = s;
        end else begin
          per_d = per_inc;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          per_d   = per_inc;
          state_d = ST_LOW;
        end else if (per_sat) begin
          timeout      = 1'b1;
          timeout_high = 1'b1;
        end else begin
          hi_d  = hi_inc;
          per_d = per_inc;
        end
      end

      ST_LOW: begin
        // A rise on the saturating cycle is still a real period, so it outranks the timeout.
        if (rise) begin
          width_d      = hi_q;
          period_d     = per_q;
          valid_d      = 1'b1;
          stuck_high_d = 1'b0;
          stuck_low_d  = 1'b0;
          hi_d         = CNT_ONE;
          per_d        = CNT_ONE;
          state_d      = ST_HIGH;
        end else if (per_sat) begin
          timeout = 1'b1;
        end else begin
          per_d = per_inc;
        end
      end

      default: state_d = ST_WAIT_RISE;
    endcase

    // A timeout restarts the period count at 1 so a constant level strobes every CNT_MAX cycles.
    if (timeout) begin
      state_d      = ST_WAIT_RISE;
      per_d        = CNT_ONE;
      width_d      = timeout_high ? CNT_MAX : '0;
      period_d     = CNT_MAX;
      valid_d      = 1'b1;
      stuck_high_d = timeout_high;
      stuck_low_d  = ~timeout_high;
    end
  end

endmodule

// File: tb/tb_pwm_demodulator.sv
// Self-checking bench for pwm_demodulator: table-driven waveforms, stuck-level and reset
// sequences, and random PWM compared against a period-level reference model.
module tb_pwm_demodulator;

  localparam int CNT_W       = 12;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int NUM_VECS    = 7;

  typedef struct {
    int edge_no;
    int width;
    int period;
    bit sh;
    bit sl;
  } strobe_t;

  typedef struct {
    int width;
    int period;
    bit sh;
    bit sl;
  } exp_t;

  typedef struct {
    int high;
    int low;
    int periods;
    int exp_width;
    int exp_period;
  } vec_t;

  logic             CLOCK_50 = 1'b0;
  logic             RST_N    = 1'b0;
  logic             pwm_in   = 1'b0;
  logic [CNT_W-1:0] meas_width;
  logic [CNT_W-1:0] meas_period;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  int      checks   = 0;
  int      errors   = 0;
  int      edge_cnt = 0;
  strobe_t seen_q[$];
  exp_t    exp_q[$];
  int      rise_q[$];
  vec_t    vecs[NUM_VECS];

  pwm_demodulator #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RST_N      (RST_N),
    .pwm_in     (pwm_in),
    .meas_width (meas_width),
    .meas_period(meas_period),
    .meas_valid (meas_valid),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) edge_cnt <= edge_cnt + 1;

  // Every strobe is logged with the number of the clock edge that raised it.
  always @(negedge CLOCK_50) begin
    if (meas_valid === 1'b1) begin
      strobe_t st;
      st.edge_no = edge_cnt;
      st.width   = int'(meas_width);
      st.period  = int'(meas_period);
      st.sh      = stuck_high;
      st.sl      = stuck_low;
      seen_q.push_back(st);
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called on a falling edge; the next rising edge is the first to sample the new level.
  task automatic apply_stimulus(input bit level, input int n);
    if (level && !pwm_in) rise_q.push_back(edge_cnt + 1);
    pwm_in = level;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_reset(input bit level);
    pwm_in = level;
    RST_N  = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    RST_N = 1'b1;
    seen_q.delete();
    rise_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_strobe(input int w, input int p, input bit sh, input bit sl);
    exp_t e;
    e.width  = w;
    e.period = p;
    e.sh     = sh;
    e.sl     = sl;
    exp_q.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_output({tag, " meas_width"},  int'(meas_width),  0);
    check_output({tag, " meas_period"}, int'(meas_period), 0);
    check_output({tag, " meas_valid"},  int'(meas_valid),  0);
    check_output({tag, " stuck_high"},  int'(stuck_high),  0);
    check_output({tag, " stuck_low"},   int'(stuck_low),   0);
  endtask

  // Strobe i of a run closes the period that began at rise i and is published by rise i+1.
  task automatic compare_strobes(input string tag, input bit chk_lat, input bit chk_space);
    check_output({tag, " strobe count"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      check_output($sformatf("%s[%0d] width", tag, i),      seen_q[i].width,  exp_q[i].width);
      check_output($sformatf("%s[%0d] period", tag, i),     seen_q[i].period, exp_q[i].period);
      check_output($sformatf("%s[%0d] stuck_high", tag, i), seen_q[i].sh,     exp_q[i].sh);
      check_output($sformatf("%s[%0d] stuck_low", tag, i),  seen_q[i].sl,     exp_q[i].sl);
      if (chk_lat && i + 1 < rise_q.size())
        check_output($sformatf("%s[%0d] latency", tag, i),
                     seen_q[i].edge_no - rise_q[i + 1], SYNC_STAGES + 1);
      if (chk_space && i > 0)
        check_output($sformatf("%s[%0d] spacing", tag, i),
                     seen_q[i].edge_no - seen_q[i - 1].edge_no, exp_q[i].period);
    end
    seen_q.delete();
    exp_q.delete();
    rise_q.delete();
  endtask

  initial begin
    vecs[0] = '{512, 1536, 3, 512, 2048};
    vecs[1] = '{1, 1, 6, 1, 2};
    vecs[2] = '{300, 700, 3, 300, 1000};
    vecs[3] = '{100, 300, 3, 100, 400};
    vecs[4] = '{100, 3995, 2, 100, 4095};
    vecs[5] = '{1, 50, 3, 1, 51};
    vecs[6] = '{2, 3, 4, 2, 5};

    @(negedge CLOCK_50);
    do_reset(1'b0);
    check_zero_outputs("reset");

    $display("[TB] table-driven waveforms");
    for (int v = 0; v < NUM_VECS; v++) begin
      do_reset(1'b0);
      apply_stimulus(1'b0, 20);
      for (int p = 0; p < vecs[v].periods; p++) begin
        apply_stimulus(1'b1, vecs[v].high);
        apply_stimulus(1'b0, vecs[v].low);
        expect_strobe(vecs[v].exp_width, vecs[v].exp_period, 1'b0, 1'b0);
      end
      apply_stimulus(1'b1, 10);
      compare_strobes($sformatf("vec%0d", v), 1'b1, 1'b1);
    end

    $display("[TB] input held high, then normal 300/700");
    do_reset(1'b1);
    apply_stimulus(1'b1, 10000);
    expect_strobe(CNT_MAX, CNT_MAX, 1'b1, 1'b0);
    expect_strobe(CNT_MAX, CNT_MAX, 1'b1, 1'b0);
    compare_strobes("held_high", 1'b0, 1'b1);
    check_output("held_high stuck_high level", int'(stuck_high), 1);
    apply_stimulus(1'b0, 700);
    for (int p = 0; p < 2; p++) begin
      apply_stimulus(1'b1, 300);
      apply_stimulus(1'b0, 700);
      expect_strobe(300, 1000, 1'b0, 1'b0);
    end
    apply_stimulus(1'b1, 10);
    compare_strobes("after_high", 1'b1, 1'b1);
    check_output("after_high stuck_high level", int'(stuck_high), 0);

    $display("[TB] input held low, then a period one cycle past saturation");
    do_reset(1'b0);
    apply_stimulus(1'b0, 10000);
    expect_strobe(0, CNT_MAX, 1'b0, 1'b1);
    expect_strobe(0, CNT_MAX, 1'b0, 1'b1);
    compare_strobes("held_low", 1'b0, 1'b1);
    check_output("held_low stuck_low level", int'(stuck_low), 1);
    check_output("held_low stuck_high level", int'(stuck_high), 0);
    apply_stimulus(1'b1, 100);
    apply_stimulus(1'b0, 3996);
    apply_stimulus(1'b1, 50);
    apply_stimulus(1'b0, 150);
    apply_stimulus(1'b1, 10);
    expect_strobe(0, CNT_MAX, 1'b0, 1'b1);
    expect_strobe(50, 200, 1'b0, 1'b0);
    compare_strobes("over_sat", 1'b0, 1'b0);

    $display("[TB] reset pulse during a high phase");
    do_reset(1'b0);
    apply_stimulus(1'b0, 20);
    apply_stimulus(1'b1, 100);
    apply_stimulus(1'b0, 300);
    apply_stimulus(1'b1, 100);
    apply_stimulus(1'b0, 300);
    apply_stimulus(1'b1, 50);
    check_output("pre_reset meas_period", int'(meas_period), 400);
    RST_N = 1'b0;
    @(negedge CLOCK_50);
    RST_N = 1'b1;
    check_zero_outputs("mid_reset");
    seen_q.delete();
    rise_q.delete();
    apply_stimulus(1'b1, 49);
    apply_stimulus(1'b0, 300);
    apply_stimulus(1'b1, 100);
    apply_stimulus(1'b0, 300);
    apply_stimulus(1'b1, 10);
    expect_strobe(100, 400, 1'b0, 1'b0);
    compare_strobes("mid_reset", 1'b1, 1'b0);

    $display("[TB] random waveforms against reference model");
    do_reset(1'b0);
    apply_stimulus(1'b0, 20);
    for (int p = 0; p < 40; p++) begin
      int h;
      int l;
      h = $urandom_range(1, 200);
      l = $urandom_range(1, 200);
      apply_stimulus(1'b1, h);
      apply_stimulus(1'b0, l);
      expect_strobe(h, h + l, 1'b0, 1'b0);
    end
    apply_stimulus(1'b1, 10);
    compare_strobes("random", 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
